bus_rr_fifo_bridge: RTL and testbench
=====================================

// Module: bus_rr_fifo_bridge
// PURPOSE
//  Parametrised successor of the single-channel req/ack packet bus. Merges NCH req/ack requester
//  channels onto one req/ack output through a DEPTH-entry FIFO with round-robin arbitration.
//  Sits between producer blocks (bus requesters) and one consumer (bus acknowledger); each entry
//  keeps its source channel index so the consumer can tell where a packet came from.
// PARAMETERS
//  W      8  packet width in bits (packed packet_t width)
//  NCH    4  number of input channels, >=2
//  DEPTH  4  FIFO entries, power of two, >=2
//  CW     $clog2(NCH)  channel-index width (derived, localparam)
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          asynchronous, active-high reset
//  in_data   in   NCH*W      channel c packet at [c*W +: W]
//  in_req    in   NCH        per-channel request, four-phase
//  in_ack    out  NCH        per-channel acknowledge, registered
//  out_data  out  W          head packet, registered, stable while out_req=1
//  out_chan  out  CW         source channel of out_data
//  out_req   out  1          output request, registered, four-phase
//  out_ack   in   1          consumer acknowledge
//  level     out  $clog2(DEPTH+1)  current FIFO occupancy
//  full      out  1          level==DEPTH
//  empty     out  1          level==0
//  hwm       out  $clog2(DEPTH+1)  high-water mark (BUS_FIFO_HWM_EN only)
// BEHAVIOUR
//  Reset: in_ack=0, out_req=0, out_data=0, out_chan=0, level=0, empty=1, full=0, rr ptr=0, hwm=0.
//  Four-phase on both sides: req up (data stable) -> ack up -> req down -> ack down.
//  Input FSM per channel: IDLE -> ACK when channel wins grant; ACK -> IDLE when in_req=0
//   (in_ack falls same edge). A channel in ACK is not eligible for grant.
//  Arbiter: eligible = in_req & IDLE & !full. One grant per cycle, round-robin starting at ptr;
//   on grant to c, ptr <= (c+1) mod NCH. Granted edge writes {c,in_data[c]} into FIFO and sets
//   in_ack[c]=1: in_ack rises 1 cycle after in_req sampled high.
//  full blocks grants; in_req held high with full=1 waits, no loss, no ack.
//  Output FSM: O_IDLE -> O_REQ when !empty: load out_data/out_chan from head, out_req<=1.
//   O_REQ -> O_WAIT on out_ack=1: pop head, out_req<=0. O_WAIT -> O_IDLE on out_ack=0.
//  Empty FIFO to out_req=1: 2 cycles after the push edge (push edge, then O_IDLE load edge).
//  Push and pop same edge: level unchanged, both pointers advance. No bypass: full is the
//   registered value, so a pop in a cycle does not enable a push in that same cycle.
//  Pointers wrap modulo DEPTH; level counts 0..DEPTH, never exceeds bounds.
//  out_ack=1 while out_req=0 (O_IDLE/O_WAIT) is ignored apart from O_WAIT exit.
//  Reset mid-handshake: all acks/req drop asynchronously, FIFO contents discarded.
// CONFIGURATION
//  `BUS_FIFO_HWM_EN defined: hwm register holds max level seen since reset, updates on the edge
//   after level rises above it; saturates at DEPTH. Undefined: hwm port still exists, tied 0,
//   no register inferred.
// TESTING (W=8, NCH=4, DEPTH=4)
//  Single: ch1 req data 8'hA5 -> in_ack[1] next cycle; out_req 2 cycles after push, out_data=A5,
//   out_chan=1; out_ack pulse-handshake -> empty=1, level=0.
//  Round-robin: ch0..ch3 req together, data 10,11,12,13 -> acks in order 0,1,2,3 on successive
//   cycles; output order 10,11,12,13 with out_chan 0..3; ch0 re-req after ack wins only after ch3.
//  Full: out_ack held 0, 5 channels' worth of reqs (ch0 twice) -> level=4, full=1, 5th req no ack
//   until one pop completes, then acked; no packet lost or duplicated.
//  Simultaneous push/pop at level=2 -> level stays 2, order preserved.
//  Reset asserted with in_ack[2]=1 and out_req=1 -> both 0 immediately, level=0, empty=1.
//  HWM_EN: fill to 3, drain to 0 -> hwm=3; without macro hwm=0 throughout.

Source files
------------

// File: rtl/bus_rr_fifo_bridge_if.sv
// Handshake bundle for bus_rr_fifo_bridge: NCH four-phase requester
// channels in, one four-phase packet stream out, plus FIFO status.
interface bus_rr_fifo_bridge_if #(
   parameter int W     = 8,
   parameter int NCH   = 4,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(NCH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [NCH*W-1:0] in_data;
   logic [NCH-1:0]   in_req;
   logic [NCH-1:0]   in_ack;
   logic [W-1:0]     out_data;
   logic [CW-1:0]    out_chan;
   logic             out_req;
   logic             out_ack;
   logic [LW-1:0]    level;
   logic             full;
   logic             empty;
   logic [LW-1:0]    hwm;

   modport master (
      input  in_data, in_req, out_ack,
      output in_ack, out_data, out_chan, out_req,
      output level, full, empty, hwm
   );

   modport slave (
      output in_data, in_req, out_ack,
      input  in_ack, out_data, out_chan, out_req,
      input  level, full, empty, hwm
   );
endinterface

// File: rtl/bus_rr_fifo_bridge.sv
// Round-robin merge of NCH req/ack channels through a DEPTH-entry FIFO.
// Define BUS_FIFO_HWM_EN to build the high-water-mark register.
module bus_rr_fifo_bridge #(
   parameter int W     = 8,
   parameter int NCH   = 4,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   bus_rr_fifo_bridge_if.master bus
);
   localparam int CW = $clog2(NCH);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic {I_IDLE, I_ACK} in_st_e;
   typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT} out_st_e;

   in_st_e          in_st_q [NCH];
   logic [NCH-1:0]  in_ack_q;
   out_st_e         out_st_q;
   logic [W-1:0]    out_data_q;
   logic [CW-1:0]   out_chan_q;
   logic            out_req_q;

   logic [CW+W-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [LW-1:0]   level_q, level_d;
   logic [CW-1:0]   rr_q, rr_d;

   logic [NCH-1:0]  elig;
   logic            gnt_v;
   logic [CW-1:0]   gnt_c;
   logic [W-1:0]    gnt_data;
   logic [CW:0]     idx;
   logic            full, empty, push, pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign push  = gnt_v;
   assign pop   = (out_st_q == O_REQ) && bus.out_ack;

   always_comb begin
      elig     = '0;
      gnt_data = '0;
      for (int c = 0; c < NCH; c++) begin
         elig[c] = bus.in_req[c] && (in_st_q[c] == I_IDLE) && !full;
         if (gnt_c == CW'(c)) gnt_data = bus.in_data[c*W +: W];
      end
   end

   // Scan channels starting at the round-robin pointer, wrapping mod NCH.
   always_comb begin
      gnt_v = 1'b0;
      gnt_c = '0;
      idx   = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = {1'b0, rr_q} + (CW+1)'(i);
         if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
         if (!gnt_v && elig[idx[CW-1:0]]) begin
            gnt_v = 1'b1;
            gnt_c = idx[CW-1:0];
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_v) rr_d = (gnt_c == CW'(NCH-1)) ? '0 : gnt_c + 1'b1;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) in_st_q[c] <= I_IDLE;
         in_ack_q <= '0;
         rr_q     <= '0;
      end else begin
         rr_q <= rr_d;
         for (int c = 0; c < NCH; c++) begin
            unique case (in_st_q[c])
               I_IDLE: if (gnt_v && gnt_c == CW'(c)) begin
                  in_st_q[c]  <= I_ACK;
                  in_ack_q[c] <= 1'b1;
               end
               I_ACK: if (!bus.in_req[c]) begin
                  in_st_q[c]  <= I_IDLE;
                  in_ack_q[c] <= 1'b0;
               end
               default: in_st_q[c] <= I_IDLE;
            endcase
         end
      end
   end

   // Storage carries no reset; validity is tracked by level_q alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {gnt_c, gnt_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
         out_st_q   <= O_IDLE;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
         out_chan_q <= '0;
      end else begin
         level_q <= level_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         unique case (out_st_q)
            O_IDLE: if (!empty) begin
               {out_chan_q, out_data_q} <= mem_q[rd_q];
               out_req_q <= 1'b1;
               out_st_q  <= O_REQ;
            end
            O_REQ: if (bus.out_ack) begin
               out_req_q <= 1'b0;
               out_st_q  <= O_WAIT;
            end
            O_WAIT: if (!bus.out_ack) out_st_q <= O_IDLE;
            default: out_st_q <= O_IDLE;
         endcase
      end
   end

`ifdef BUS_FIFO_HWM_EN
   logic [LW-1:0] hwm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hwm_q <= '0;
      else if (level_q > hwm_q) hwm_q <= level_q;
   end

   assign bus.hwm = hwm_q;
`else
   assign bus.hwm = '0;
`endif

   assign bus.in_ack   = in_ack_q;
   assign bus.out_data = out_data_q;
   assign bus.out_chan = out_chan_q;
   assign bus.out_req  = out_req_q;
   assign bus.level    = level_q;
   assign bus.full     = full;
   assign bus.empty    = empty;
endmodule

// File: tb/tb_bus_rr_fifo_bridge.sv
// Directed and randomized bench for bus_rr_fifo_bridge (W=8, NCH=4, DEPTH=4);
// hwm expectations follow BUS_FIFO_HWM_EN.
module tb_bus_rr_fifo_bridge;
   localparam int W = 8;
   localparam int NCH = 4;
   localparam int DEPTH = 4;
`ifdef BUS_FIFO_HWM_EN
   localparam bit HWM_ON = 1'b1;
`else
   localparam bit HWM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   logic [7:0] expq [NCH][$];

   bus_rr_fifo_bridge_if #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) bus ();

   bus_rr_fifo_bridge #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_data(input int c, input logic [7:0] d);
      bus.in_data[c*W +: W] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_req = '0;
      bus.out_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic drain_one(input string tag, input logic [7:0] d,
                            input logic [1:0] c);
      int n = 0;
      while (!bus.out_req && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, bus.out_req, 1);
      chk({tag, "_data"}, bus.out_data, d);
      chk({tag, "_chan"}, bus.out_chan, c);
      bus.out_ack = 1'b1;
      step();
      chk({tag, "_reqlo"}, bus.out_req, 0);
      bus.out_ack = 1'b0;
      step();
   endtask

   // One cycle of random producers and consumer; the scoreboard keeps one
   // FIFO of committed packets per channel, independent of arbitration.
   task automatic rand_cycle(input bit allow);
      logic [7:0] d;
      int c;
      chk("rnd_full", bus.full, bus.level == 3'd4);
      chk("rnd_empty", bus.empty, bus.level == 3'd0);
      chk("rnd_bound", bus.level <= 3'd4, 1);
      for (int k = 0; k < NCH; k++) begin
         if (bus.in_req[k] && bus.in_ack[k]) begin
            bus.in_req[k] = 1'b0;
         end else if (allow && !bus.in_req[k] && !bus.in_ack[k] &&
                      $urandom_range(2) == 0) begin
            d = 8'($urandom);
            set_data(k, d);
            expq[k].push_back(d);
            bus.in_req[k] = 1'b1;
         end
      end
      if (bus.out_req && !bus.out_ack && $urandom_range(1) == 1) begin
         c = int'(bus.out_chan);
         chk("rnd_known", expq[c].size() > 0, 1);
         if (expq[c].size() > 0) begin
            chk("rnd_data", bus.out_data, expq[c][0]);
            void'(expq[c].pop_front());
         end
         bus.out_ack = 1'b1;
      end else if (!bus.out_req && bus.out_ack) begin
         bus.out_ack = 1'b0;
      end
      step();
   endtask

   initial begin
      int left;
      rst = 1'b1;
      bus.in_data = '0;
      bus.in_req = '0;
      bus.out_ack = 1'b0;
      step();
      step();
      chk("rst_inack", bus.in_ack, 0);
      chk("rst_outreq", bus.out_req, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_chan", bus.out_chan, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_hwm", bus.hwm, 0);
      rst = 1'b0;
      step();

      // single packet on channel 1
      set_data(1, 8'hA5);
      bus.in_req[1] = 1'b1;
      step();
      chk("sgl_ack", bus.in_ack, 4'b0010);
      chk("sgl_lvl", bus.level, 1);
      chk("sgl_req0", bus.out_req, 0);
      bus.in_req[1] = 1'b0;
      step();
      chk("sgl_req", bus.out_req, 1);
      chk("sgl_data", bus.out_data, 8'hA5);
      chk("sgl_chan", bus.out_chan, 1);
      chk("sgl_ackdn", bus.in_ack, 0);
      bus.out_ack = 1'b1;
      step();
      chk("sgl_reqlo", bus.out_req, 0);
      chk("sgl_lvl0", bus.level, 0);
      chk("sgl_empty", bus.empty, 1);
      bus.out_ack = 1'b0;
      step();

      // round-robin, then full with ch0 re-requesting
      do_reset();
      for (int k = 0; k < NCH; k++) set_data(k, 8'(8'h10 + k));
      bus.in_req = 4'hF;
      step();
      chk("rr_ack0", bus.in_ack, 4'b0001);
      chk("rr_lvl1", bus.level, 1);
      bus.in_req[0] = 1'b0;
      step();
      chk("rr_ack1", bus.in_ack, 4'b0010);
      chk("rr_lvl2", bus.level, 2);
      chk("rr_oreq", bus.out_req, 1);
      chk("rr_odata", bus.out_data, 8'h10);
      chk("rr_ochan", bus.out_chan, 0);
      bus.in_req[1] = 1'b0;
      set_data(0, 8'h14);
      bus.in_req[0] = 1'b1;
      step();
      chk("rr_ack2", bus.in_ack, 4'b0100);
      chk("rr_lvl3", bus.level, 3);
      bus.in_req[2] = 1'b0;
      step();
      chk("rr_ack3", bus.in_ack, 4'b1000);
      chk("rr_lvl4", bus.level, 4);
      chk("rr_full", bus.full, 1);
      bus.in_req[3] = 1'b0;
      step();
      chk("full_noack", bus.in_ack, 0);
      chk("full_lvl", bus.level, 4);
      step();
      chk("full_noack2", bus.in_ack, 0);
      bus.out_ack = 1'b1;
      step();
      chk("full_pop_lvl", bus.level, 3);
      chk("full_pop_ack", bus.in_ack, 0);
      chk("full_pop_req", bus.out_req, 0);
      bus.out_ack = 1'b0;
      step();
      chk("full_late_ack", bus.in_ack, 4'b0001);
      chk("full_relvl", bus.level, 4);
      bus.in_req[0] = 1'b0;
      drain_one("rr_o1", 8'h11, 2'd1);
      drain_one("rr_o2", 8'h12, 2'd2);
      drain_one("rr_o3", 8'h13, 2'd3);
      drain_one("rr_o0", 8'h14, 2'd0);
      chk("rr_end_lvl", bus.level, 0);
      chk("rr_end_empty", bus.empty, 1);

      // simultaneous push and pop at level 2
      set_data(1, 8'h21);
      set_data(2, 8'h22);
      bus.in_req[1] = 1'b1;
      bus.in_req[2] = 1'b1;
      step();
      chk("pp_ack1", bus.in_ack, 4'b0010);
      bus.in_req[1] = 1'b0;
      step();
      chk("pp_ack2", bus.in_ack, 4'b0100);
      chk("pp_lvl2", bus.level, 2);
      chk("pp_data", bus.out_data, 8'h21);
      bus.in_req[2] = 1'b0;
      set_data(3, 8'h23);
      bus.in_req[3] = 1'b1;
      bus.out_ack = 1'b1;
      step();
      chk("pp_lvl_same", bus.level, 2);
      chk("pp_ack3", bus.in_ack, 4'b1000);
      chk("pp_reqlo", bus.out_req, 0);
      bus.in_req[3] = 1'b0;
      bus.out_ack = 1'b0;
      step();
      drain_one("pp_o2", 8'h22, 2'd2);
      drain_one("pp_o3", 8'h23, 2'd3);

      // asynchronous reset mid-handshake
      do_reset();
      set_data(1, 8'h31);
      bus.in_req[1] = 1'b1;
      step();
      bus.in_req[1] = 1'b0;
      set_data(2, 8'h32);
      bus.in_req[2] = 1'b1;
      step();
      chk("ar_pre_ack", bus.in_ack, 4'b0100);
      chk("ar_pre_req", bus.out_req, 1);
      #1 rst = 1'b1;
      #1;
      chk("ar_inack", bus.in_ack, 0);
      chk("ar_outreq", bus.out_req, 0);
      chk("ar_level", bus.level, 0);
      chk("ar_empty", bus.empty, 1);
      bus.in_req = '0;
      step();
      rst = 1'b0;
      step();
      chk("ar_post_lvl", bus.level, 0);
      chk("ar_post_req", bus.out_req, 0);

      // high-water mark: fill to 3, drain to 0
      do_reset();
      for (int k = 0; k < 3; k++) set_data(k, 8'(8'h41 + k));
      bus.in_req = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         step();
         bus.in_req[k] = 1'b0;
      end
      step();
      chk("hwm_lvl3", bus.level, 3);
      drain_one("hwm_o0", 8'h41, 2'd0);
      drain_one("hwm_o1", 8'h42, 2'd1);
      drain_one("hwm_o2", 8'h43, 2'd2);
      chk("hwm_lvl0", bus.level, 0);
      chk("hwm_val", bus.hwm, HWM_ON ? 3 : 0);

      // randomized traffic against the per-channel scoreboard
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         left = 0;
         for (int k = 0; k < NCH; k++) left += expq[k].size();
         if (cyc >= 3000 && left == 0 && bus.in_req == '0) break;
         rand_cycle(cyc < 3000);
      end
      left = 0;
      for (int k = 0; k < NCH; k++) left += expq[k].size();
      chk("rnd_left", left, 0);
      chk("rnd_end_lvl", bus.level, 0);
      chk("rnd_hwm", bus.hwm, HWM_ON ? 4 : 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
